key_cmd_queue: RTL and testbench

KEY_CMD_QUEUE -- requirements
Module: key_cmd_queue

---
 rtl/key_cmd_queue.sv | 165 ++++++++++++++++
 tb/tb_key_cmd_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : key_cmd_queue
// Description : Turns debounced key press/release pulses into command codes
//               (A/S/W/D presses, short and long presses of X) and queues
//               them in a small FIFO with a valid/ready consumer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module key_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       buttom_rst,
    input  logic       sign_pos_A,
    input  logic       sign_pos_S,
    input  logic       sign_pos_W,
    input  logic       sign_pos_D,
    input  logic       sign_pos_X,
    input  logic       sign_neg_X,
    output logic [2:0] cmd_code,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [4:0] fifo_count,
    output logic       overflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(LONG_CYCLES + 1);

    localparam logic [2:0] c_CODE_A       = 3'd1;
    localparam logic [2:0] c_CODE_S       = 3'd2;
    localparam logic [2:0] c_CODE_W       = 3'd3;
    localparam logic [2:0] c_CODE_X_SHORT = 3'd4;
    localparam logic [2:0] c_CODE_D       = 3'd5;
    localparam logic [2:0] c_CODE_X_LONG  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_LONG_WAIT = 2'd2
    } x_state_t;

    x_state_t               state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]             mem_q [DEPTH];
    logic [2:0]             mem_d [DEPTH];
    logic [c_ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [4:0]             count_q, count_d;
    logic                   overflow_q, overflow_d;

    logic                   w_x_evt;
    logic [2:0]             w_x_code;
    logic [2:0]             w_n_evt;
    logic                   w_push;
    logic [2:0]             w_push_code;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_ok;

    // X tracker: release is resolved before press so a same-cycle pair
    // closes the old press and then starts a fresh one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_x_evt  = 1'b0;
        w_x_code = 3'd0;
        case (state_q)
            ST_IDLE: begin
            end
            ST_HELD: begin
                if (cnt_q >= c_CNT_W'(LONG_CYCLES)) begin
                    w_x_evt  = 1'b1;
                    w_x_code = c_CODE_X_LONG;
                    state_d  = sign_neg_X ? ST_IDLE : ST_LONG_WAIT;
                end else if (sign_neg_X) begin
                    w_x_evt  = 1'b1;
                    w_x_code = c_CODE_X_SHORT;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            ST_LONG_WAIT: begin
                if (sign_neg_X) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (sign_pos_X) begin
            state_d = ST_HELD;
            cnt_d   = c_CNT_W'(1);
        end
    end

    // One push per cycle by fixed priority; extra events and pushes into a
    // full queue (without a simultaneous pop) are lost and flagged.
    always_comb begin
        w_n_evt = 3'(w_x_evt) + 3'(sign_pos_A) + 3'(sign_pos_S)
                + 3'(sign_pos_W) + 3'(sign_pos_D);
        w_push      = (w_n_evt != 3'd0);
        w_push_code = 3'd0;
        if (w_x_evt)         w_push_code = w_x_code;
        else if (sign_pos_A) w_push_code = c_CODE_A;
        else if (sign_pos_S) w_push_code = c_CODE_S;
        else if (sign_pos_W) w_push_code = c_CODE_W;
        else if (sign_pos_D) w_push_code = c_CODE_D;

        w_pop     = (count_q != 5'd0) && cmd_ready;
        w_full    = (count_q == 5'(DEPTH));
        w_push_ok = w_push && (!w_full || w_pop);

        overflow_d = overflow_q || (w_n_evt > 3'd1) || (w_push && w_full && !w_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = w_push_code;
            wr_ptr_d        = wr_ptr_q + c_ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ADDR_W'(1);
        end

        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards tracker, queue and sticky flag.
    always_ff @(posedge clk) begin
        if (buttom_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_q      <= '{default: 3'd0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs come straight from registers, so no input reaches them combinationally.
    always_comb begin
        cmd_valid  = (count_q != 5'd0);
        cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
        fifo_count = count_q;
        overflow   = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_cmd_queue
// Description : Scoreboard bench for key_cmd_queue (DEPTH=4, LONG_CYCLES=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_cmd_queue;

    logic       clk = 1'b0;
    logic       buttom_rst = 1'b1;
    logic       sign_pos_A = 1'b0;
    logic       sign_pos_S = 1'b0;
    logic       sign_pos_W = 1'b0;
    logic       sign_pos_D = 1'b0;
    logic       sign_pos_X = 1'b0;
    logic       sign_neg_X = 1'b0;
    logic [2:0] cmd_code;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [2:0]  exp_q[$];

    key_cmd_queue #(
        .DEPTH      (4),
        .LONG_CYCLES(10)
    ) u_dut (
        .clk       (clk),
        .buttom_rst(buttom_rst),
        .sign_pos_A(sign_pos_A),
        .sign_pos_S(sign_pos_S),
        .sign_pos_W(sign_pos_W),
        .sign_pos_D(sign_pos_D),
        .sign_pos_X(sign_pos_X),
        .sign_neg_X(sign_neg_X),
        .cmd_code  (cmd_code),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sign_pos_A = 1'b0;
        sign_pos_S = 1'b0;
        sign_pos_W = 1'b0;
        sign_pos_D = 1'b0;
        sign_pos_X = 1'b0;
        sign_neg_X = 1'b0;
    endtask

    task automatic do_reset();
        buttom_rst = 1'b1;
        tick();
        tick();
        buttom_rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        cmd_ready = 1'b1;
        while ((exp_q.size() != 0 || cmd_valid) && guard < 20) begin
            tick();
            guard++;
        end
        cmd_ready = 1'b0;
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_code"}, cmd_code, 0);
    endtask

    // Consumer side: each accepted head is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!buttom_rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop got %0d expected none", cmd_code);
            end else begin
                chk("pop_code", cmd_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);

        // A, S, W queued while consumer stalls, then drained in order
        sign_pos_A = 1'b1; exp_q.push_back(3'd1); tick(); clear_inputs();
        chk("lat_valid", cmd_valid, 1);
        chk("lat_code", cmd_code, 1);
        sign_pos_S = 1'b1; exp_q.push_back(3'd2); tick(); clear_inputs();
        sign_pos_W = 1'b1; exp_q.push_back(3'd3); tick(); clear_inputs();
        tick();
        chk("asw_count", fifo_count, 3);
        chk("asw_head_stable", cmd_code, 1);
        drain("asw");

        // Short X press: release 5 cycles after press
        sign_pos_X = 1'b1; tick(); clear_inputs();
        repeat (4) tick();
        sign_neg_X = 1'b1; exp_q.push_back(3'd4); tick(); clear_inputs();
        chk("short_count", fifo_count, 1);
        chk("short_code", cmd_code, 4);
        drain("short");

        // Long X press: code 6 appears exactly 10 cycles after the press
        sign_pos_X = 1'b1; tick(); clear_inputs();
        repeat (9) tick();
        chk("long_early", cmd_valid, 0);
        tick();
        exp_q.push_back(3'd6);
        chk("long_valid", cmd_valid, 1);
        chk("long_code", cmd_code, 6);
        repeat (4) tick();
        sign_neg_X = 1'b1; tick(); clear_inputs();
        repeat (3) tick();
        chk("long_release_count", fifo_count, 1);
        drain("long");

        // Same-cycle release+press with S: short emitted, S dropped, new press restarts
        sign_pos_X = 1'b1; tick(); clear_inputs();
        tick();
        sign_neg_X = 1'b1; sign_pos_X = 1'b1; sign_pos_S = 1'b1;
        exp_q.push_back(3'd4); tick(); clear_inputs();
        chk("relpress_count", fifo_count, 1);
        chk("relpress_ovf", overflow, 1);
        tick();
        sign_neg_X = 1'b1; exp_q.push_back(3'd4); tick(); clear_inputs();
        chk("relpress_second", fifo_count, 2);
        drain("relpress");

        // A and D together: only A kept, overflow sticky
        do_reset();
        chk("rst2_ovf", overflow, 0);
        sign_pos_A = 1'b1; sign_pos_D = 1'b1; exp_q.push_back(3'd1); tick(); clear_inputs();
        chk("ad_count", fifo_count, 1);
        chk("ad_code", cmd_code, 1);
        chk("ad_ovf", overflow, 1);
        drain("ad");
        chk("ad_ovf_sticky", overflow, 1);

        // Five D into a depth-4 queue, then push+pop while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sign_pos_D = 1'b1;
            if (i < 4) exp_q.push_back(3'd5);
            tick();
            clear_inputs();
        end
        chk("full_count", fifo_count, 4);
        chk("full_ovf", overflow, 1);
        chk("full_head", cmd_code, 5);
        sign_pos_A = 1'b1; cmd_ready = 1'b1; exp_q.push_back(3'd1); tick();
        clear_inputs(); cmd_ready = 1'b0;
        chk("fullpp_count", fifo_count, 4);
        drain("full");

        // Reset while X is held: later release produces nothing
        do_reset();
        sign_pos_X = 1'b1; tick(); clear_inputs();
        tick(); tick();
        buttom_rst = 1'b1; tick(); buttom_rst = 1'b0;
        sign_neg_X = 1'b1; tick(); clear_inputs();
        repeat (12) tick();
        chk("xrst_count", fifo_count, 0);
        chk("xrst_valid", cmd_valid, 0);
        chk("xrst_code", cmd_code, 0);
        chk("xrst_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
